// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider.
package clk_div_pkg;

    // Divider run state: IDLE while en is low, RUN while en is high.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Default width of counter, divisor and high-count.
    localparam int DEF_WIDTH = 28;

endpackage

// File: rtl/clk_div_prog.sv
// Programmable clock divider: period and high-phase length come from a
// double-buffered config (shadow -> active) so a running period is never
// disturbed by a new setting. clk_out and tick are registered.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH        = DEF_WIDTH,
    parameter int unsigned DEFAULT_DIV  = 13,
    parameter int unsigned DEFAULT_HIGH = 6,
    parameter logic        IDLE_LEVEL   = 1'b0
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic [WIDTH-1:0] cfg_high,
    output logic             clk_out,
    output logic             tick,
    output logic             cfg_pending
);

    // A divisor below 2 cannot produce a period with both phases, so it
    // is raised to 2 when it becomes active.
    function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
        return (d < WIDTH'(2)) ? WIDTH'(2) : d;
    endfunction

    localparam logic [WIDTH-1:0] RST_DIV  = clamp_div(WIDTH'(DEFAULT_DIV));
    localparam logic [WIDTH-1:0] RST_HIGH = WIDTH'(DEFAULT_HIGH);

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div_a;
    logic [WIDTH-1:0] r_high_a;
    logic [WIDTH-1:0] r_div_s;
    logic [WIDTH-1:0] r_high_s;
    logic             r_pend;
    logic             r_clk;
    logic             r_tick;

    state_t           w_state_n;
    logic [WIDTH-1:0] w_cnt_n;
    logic [WIDTH-1:0] w_div_a_n;
    logic [WIDTH-1:0] w_high_a_n;
    logic [WIDTH-1:0] w_div_s_n;
    logic [WIDTH-1:0] w_high_s_n;
    logic             w_pend_n;
    logic             w_clk_n;
    logic             w_tick_n;
    logic             w_last;
    logic             w_xfer;

    assign w_last = (r_cnt == (r_div_a - WIDTH'(1)));

    // Next-state logic: counter, shadow/active transfer and the output
    // values that belong to the counter value entering the next cycle.
    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_div_a_n  = r_div_a;
        w_high_a_n = r_high_a;
        w_div_s_n  = r_div_s;
        w_high_s_n = r_high_s;
        w_pend_n   = r_pend;
        w_clk_n    = IDLE_LEVEL;
        w_tick_n   = 1'b0;
        w_xfer     = 1'b0;

        // A new write always lands in the shadow; last write wins.
        if (cfg_load) begin
            w_div_s_n  = cfg_div;
            w_high_s_n = cfg_high;
            w_pend_n   = 1'b1;
        end

        case (r_state)
            IDLE: begin
                w_cnt_n = '0;
                if (en) begin
                    w_state_n = RUN;
                    w_xfer    = r_pend && !cfg_load;
                end
            end
            RUN: begin
                if (!en) begin
                    w_state_n = IDLE;
                    w_cnt_n   = '0;
                end else if (w_last) begin
                    w_cnt_n = '0;
                    // A write on the wrap edge itself waits for the next wrap.
                    w_xfer  = r_pend && !cfg_load;
                end else begin
                    w_cnt_n = r_cnt + WIDTH'(1);
                end
            end
            default: begin
                w_state_n = IDLE;
                w_cnt_n   = '0;
            end
        endcase

        if (w_xfer) begin
            w_div_a_n  = clamp_div(r_div_s);
            w_high_a_n = r_high_s;
            w_pend_n   = 1'b0;
        end

        if (w_state_n == RUN) begin
            w_clk_n  = (w_cnt_n < w_high_a_n);
            w_tick_n = (w_cnt_n == (w_div_a_n - WIDTH'(1)));
        end
    end

    // State register; reset restores defaults and drops any pending write.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_div_a  <= RST_DIV;
            r_high_a <= RST_HIGH;
            r_div_s  <= RST_DIV;
            r_high_s <= RST_HIGH;
            r_pend   <= 1'b0;
            r_clk    <= IDLE_LEVEL;
            r_tick   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_div_a  <= w_div_a_n;
            r_high_a <= w_high_a_n;
            r_div_s  <= w_div_s_n;
            r_high_s <= w_high_s_n;
            r_pend   <= w_pend_n;
            r_clk    <= w_clk_n;
            r_tick   <= w_tick_n;
        end
    end

    assign clk_out     = r_clk;
    assign tick        = r_tick;
    assign cfg_pending = r_pend;

endmodule
